// File: rtl/alpaca_dtypes_pkg.sv
// Shared types and constants for the PFB spectrometer datapath.
package alpaca_dtypes_pkg;

  localparam int unsigned PACC_LAT = 4;
  localparam int unsigned PWR_W    = 40;

  typedef logic [PWR_W-1:0] pwr_t;
  typedef logic [15:0]      acc_seq_t;

endpackage

// File: rtl/cx_power.sv
// Pipelined |X|^2 for one complex lane: squares in stage 1, sum in stage 2.
module cx_power #(
  parameter int unsigned IN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   re,
  input  logic [IN_W-1:0]   im,
  output logic [2*IN_W-1:0] p
);

  logic signed [2*IN_W-1:0] re_x, im_x;
  logic        [2*IN_W-1:0] re_sq_q, im_sq_q;

  assign re_x = {{IN_W{re[IN_W-1]}}, re};
  assign im_x = {{IN_W{im[IN_W-1]}}, im};

  // Each square is non-negative and fits 2*IN_W-1 bits; the sum fits 2*IN_W unsigned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      p       <= '0;
    end else if (en) begin
      re_sq_q <= re_x * re_x;
      im_sq_q <= im_x * im_x;
      p       <= re_sq_q + im_sq_q;
    end
  end

endmodule

// File: rtl/ospfb_power_acc.sv
// Power-spectrum integrator: |X|^2 per bin accumulated over ACC_LEN frames in on-chip RAM.
// Lane l of s_axis_tdata: re at [l*2*IN_W +: IN_W], im above it. Macro: OSPFB_ACC_SAT_EN.
module ospfb_power_acc
  import alpaca_dtypes_pkg::*;
#(
  parameter int unsigned FFT_LEN      = 64,
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned ACC_LEN      = 4,
  parameter int unsigned IN_W         = 16,
  parameter int unsigned ACC_W        = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SAMP_PER_CLK*2*IN_W-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [SAMP_PER_CLK*ACC_W-1:0]  m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [15:0]                    m_axis_tuser,
  output logic                           acc_overflow,
  output logic                           event_tlast_unexpected,
  output logic                           event_tlast_missing
);

  localparam int unsigned NBEAT  = FFT_LEN / SAMP_PER_CLK;
  localparam int unsigned BEAT_W = $clog2(NBEAT);
  localparam int unsigned FRM_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int unsigned P_W    = 2 * IN_W;
  localparam int unsigned WORD_W = SAMP_PER_CLK * ACC_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEAT - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(ACC_LEN - 1);

  typedef struct packed {
    logic [BEAT_W-1:0] beat;
    logic              first;
    logic              dump;
  } meta_t;

  logic                           en;
  logic [BEAT_W-1:0]              beat_q;
  logic [FRM_W-1:0]               frm_q;
  logic                           beat_is_last, frm_is_last;
  logic [PACC_LAT-2:0]            vld_q;
  meta_t                          meta_q [PACC_LAT-1];
  logic [SAMP_PER_CLK*2*IN_W-1:0] data_s0;
  logic [SAMP_PER_CLK*P_W-1:0]    p_s2;
  logic [WORD_W-1:0]              rd_s1, rd_s2, acc_word;
  logic                           ovf_any;
  logic [WORD_W-1:0]              mem [NBEAT];
  acc_seq_t                       seq_q;

  // Only a held, unconsumed output can stall; everything freezes together.
  assign en            = ~(m_axis_tvalid & ~m_axis_tready);
  assign s_axis_tready = en;
  assign beat_is_last  = (beat_q == BEAT_LAST);
  assign frm_is_last   = (frm_q == FRM_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q                 <= '0;
      frm_q                  <= '0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
    end else begin
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
      if (s_axis_tvalid && en) begin
        if (s_axis_tlast && !beat_is_last) begin
          // Early frame end: abandon the partial integration and restart at frame 0.
          event_tlast_unexpected <= 1'b1;
          beat_q                 <= '0;
          frm_q                  <= '0;
        end else if (beat_is_last) begin
          event_tlast_missing <= ~s_axis_tlast;
          beat_q              <= '0;
          frm_q               <= frm_is_last ? '0 : frm_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      data_s0 <= '0;
      for (int i = 0; i < int'(PACC_LAT) - 1; i++) meta_q[i] <= '0;
    end else if (en) begin
      vld_q     <= {vld_q[PACC_LAT-3:0], s_axis_tvalid};
      data_s0   <= s_axis_tdata;
      meta_q[0] <= '{beat: beat_q, first: (frm_q == '0), dump: frm_is_last};
      for (int i = 1; i < int'(PACC_LAT) - 1; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  for (genvar l = 0; l < SAMP_PER_CLK; l++) begin : g_lane
    cx_power #(
      .IN_W (IN_W)
    ) u_cx_power (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .re  (data_s0[l*2*IN_W +: IN_W]),
      .im  (data_s0[l*2*IN_W+IN_W +: IN_W]),
      .p   (p_s2[l*P_W +: P_W])
    );
  end

  // Same-address beats are >= 4 accepts apart, so the write lands before the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_s1 <= mem[meta_q[0].beat];
      rd_s2 <= rd_s1;
      if (vld_q[PACC_LAT-2]) mem[meta_q[PACC_LAT-2].beat] <= acc_word;
    end
  end

  always_comb begin
    acc_word = '0;
    ovf_any  = 1'b0;
    for (int l = 0; l < int'(SAMP_PER_CLK); l++) begin
      logic [ACC_W-1:0] base;
      logic [ACC_W:0]   sum;
      base    = meta_q[PACC_LAT-2].first ? '0 : rd_s2[l*ACC_W +: ACC_W];
      sum     = {1'b0, base} + (ACC_W+1)'(p_s2[l*P_W +: P_W]);
      ovf_any = ovf_any | sum[ACC_W];
`ifdef OSPFB_ACC_SAT_EN
      acc_word[l*ACC_W +: ACC_W] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_word[l*ACC_W +: ACC_W] = sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      seq_q         <= '0;
      acc_overflow  <= 1'b0;
    end else if (en) begin
      m_axis_tvalid <= vld_q[PACC_LAT-2] & meta_q[PACC_LAT-2].dump;
      if (vld_q[PACC_LAT-2] && ovf_any) acc_overflow <= 1'b1;
      if (vld_q[PACC_LAT-2] && meta_q[PACC_LAT-2].dump) begin
        m_axis_tdata <= acc_word;
        m_axis_tlast <= (meta_q[PACC_LAT-2].beat == BEAT_LAST);
        m_axis_tuser <= seq_q;
        if (meta_q[PACC_LAT-2].beat == BEAT_LAST) seq_q <= seq_q + 1'b1;
      end
    end
  end

endmodule
